// File: rtl/pic_pkg.sv
// Shared types, OCW2 command encodings and the rotating priority search
// for the interrupt sequencer slice.
package pic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK1 = 2'd1,
        ST_ACK2 = 2'd2
    } pic_state_e;

    localparam logic [2:0] EOI_NONSPEC     = 3'b001;
    localparam logic [2:0] EOI_SPEC        = 3'b011;
    localparam logic [2:0] EOI_ROT_NONSPEC = 3'b101;
    localparam logic [2:0] EOI_ROT_SPEC    = 3'b111;
    localparam logic [2:0] EOI_SET_PRIO    = 3'b110;

    localparam logic [7:0] SPURIOUS_LATCH  = 8'h80;

    typedef struct packed {
        logic       found;
        logic [2:0] level;
    } prio_hit_t;

    // Walks from lowest to highest priority so the last hit is the winner.
    function automatic prio_hit_t find_highest(input logic [7:0] bits, input logic [2:0] start);
        prio_hit_t  hit;
        logic [2:0] idx;
        hit = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (bits[idx]) begin
                hit.found = 1'b1;
                hit.level = idx;
            end
        end
        return hit;
    endfunction

    function automatic logic [2:0] encode_level(input logic [7:0] onehot);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                lvl = 3'(i);
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pic_irr_latch.sv
// Interrupt request register: edge/level capture of the raw IR lines with
// acknowledge clear, where a fresh set condition beats the clear.
module pic_irr_latch (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir_in,
    input  logic       ltim,
    input  logic [7:0] ack_clr,
    output logic [7:0] irr
);

    logic [7:0] ir_prev_q;
    logic [7:0] irr_q;
    logic [7:0] irr_d;
    logic [7:0] set_cond;

    // A dropped line always clears; a held request survives unless acknowledged.
    always_comb begin
        set_cond = ltim ? ir_in : (ir_in & ~ir_prev_q);
        irr_d    = set_cond | (irr_q & ir_in & ~ack_clr);
    end

    // ir_prev resets high so lines already asserted at reset never look like edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_prev_q <= 8'hFF;
            irr_q     <= 8'h00;
        end else begin
            ir_prev_q <= ir_in;
            irr_q     <= irr_d;
        end
    end

    assign irr = irr_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// INTA sequencing FSM, in-service register, EOI/rotation handling and
// vector strobe for an 8259-style interrupt controller.
module interrupt_sequencer
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir_in,
    input  logic       ltim,
    input  logic       auto_eoi,
    input  logic       inta_pulse,
    input  logic       eoi_valid,
    input  logic [2:0] eoi_cmd,
    input  logic [2:0] eoi_level,
    input  logic [7:0] interrupt_vector,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] priority_rotate,
    output logic       int_out,
    output logic [2:0] vector_index,
    output logic       vector_valid
);

    pic_state_e state_q, state_d;
    logic [7:0] ack_latch_q, ack_latch_d;
    logic       ack_spur_q, ack_spur_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] prio_q, prio_d;
    logic       int_out_q, int_out_d;
    logic [2:0] vec_idx_q, vec_idx_d;
    logic       vec_valid_q, vec_valid_d;

    logic [7:0] ack_clr;
    logic [7:0] ack_set;
    logic [7:0] eoi_clr;
    logic [7:0] auto_clr;
    prio_hit_t  hit;

    assign ack_clr = (state_q == ST_IDLE && inta_pulse) ? interrupt_vector : 8'h00;

    pic_irr_latch u_irr (
        .clk     (clk),
        .rst_n   (rst_n),
        .ir_in   (ir_in),
        .ltim    (ltim),
        .ack_clr (ack_clr),
        .irr     (irr)
    );

    always_comb begin
        state_d     = state_q;
        ack_latch_d = ack_latch_q;
        ack_spur_d  = ack_spur_q;
        prio_d      = prio_q;
        vec_idx_d   = vec_idx_q;
        vec_valid_d = 1'b0;
        ack_set     = 8'h00;
        eoi_clr     = 8'h00;
        auto_clr    = 8'h00;
        hit         = find_highest(isr_q, prio_q);

        // EOI works on the pre-cycle ISR; the other OCW2 codes fall to the no-op default.
        if (eoi_valid) begin
            case (eoi_cmd)
                EOI_NONSPEC: begin
                    if (hit.found) eoi_clr[hit.level] = 1'b1;
                end
                EOI_SPEC: begin
                    eoi_clr[eoi_level] = 1'b1;
                end
                EOI_ROT_NONSPEC: begin
                    if (hit.found) begin
                        eoi_clr[hit.level] = 1'b1;
                        prio_d             = hit.level + 3'd1;
                    end
                end
                EOI_ROT_SPEC: begin
                    eoi_clr[eoi_level] = 1'b1;
                    prio_d             = eoi_level + 3'd1;
                end
                EOI_SET_PRIO: begin
                    prio_d = eoi_level + 3'd1;
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (inta_pulse) begin
                    state_d = ST_ACK1;
                    if (interrupt_vector == 8'h00) begin
                        ack_latch_d = SPURIOUS_LATCH;
                        ack_spur_d  = 1'b1;
                    end else begin
                        ack_latch_d = interrupt_vector;
                        ack_spur_d  = 1'b0;
                        ack_set     = interrupt_vector;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_pulse) begin
                    state_d     = ST_ACK2;
                    vec_idx_d   = encode_level(ack_latch_q);
                    vec_valid_d = 1'b1;
                    if (auto_eoi && !ack_spur_q) auto_clr = ack_latch_q;
                end
            end
            ST_ACK2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        isr_d     = (isr_q & ~(eoi_clr | auto_clr)) | ack_set;
        int_out_d = (state_d == ST_IDLE) && (interrupt_vector != 8'h00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ack_latch_q <= 8'h00;
            ack_spur_q  <= 1'b0;
            isr_q       <= 8'h00;
            prio_q      <= 3'd0;
            int_out_q   <= 1'b0;
            vec_idx_q   <= 3'd0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_latch_q <= ack_latch_d;
            ack_spur_q  <= ack_spur_d;
            isr_q       <= isr_d;
            prio_q      <= prio_d;
            int_out_q   <= int_out_d;
            vec_idx_q   <= vec_idx_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    assign isr             = isr_q;
    assign priority_rotate = prio_q;
    assign int_out         = int_out_q;
    assign vector_index    = vec_idx_q;
    assign vector_valid    = vec_valid_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: the bench plays the priority
// resolver and bus interface, and every expected value is hand-computed.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir_in;
    logic       ltim;
    logic       auto_eoi;
    logic       inta_pulse;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic [7:0] interrupt_vector;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] priority_rotate;
    logic       int_out;
    logic [2:0] vector_index;
    logic       vector_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ir_in            (ir_in),
        .ltim             (ltim),
        .auto_eoi         (auto_eoi),
        .inta_pulse       (inta_pulse),
        .eoi_valid        (eoi_valid),
        .eoi_cmd          (eoi_cmd),
        .eoi_level        (eoi_level),
        .interrupt_vector (interrupt_vector),
        .irr              (irr),
        .isr              (isr),
        .priority_rotate  (priority_rotate),
        .int_out          (int_out),
        .vector_index     (vector_index),
        .vector_valid     (vector_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then waits until just after the next rising edge.
    task automatic applyStimulus(input logic [7:0] irIn, input logic [7:0] vec, input logic inta,
                                 input logic eoiV, input logic [2:0] cmd, input logic [2:0] lvl);
        ir_in            = irIn;
        interrupt_vector = vec;
        inta_pulse       = inta;
        eoi_valid        = eoiV;
        eoi_cmd          = cmd;
        eoi_level        = lvl;
        tick();
    endtask

    task automatic applyEoi(input logic [2:0] cmd, input logic [2:0] lvl);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b1, cmd, lvl);
    endtask

    task automatic runInta(input logic [7:0] vec);
        applyStimulus(8'h00, vec,   1'b1, 1'b0, 3'd0, 3'd0);
        applyStimulus(8'h00, vec,   1'b0, 1'b0, 3'd0, 3'd0);
        applyStimulus(8'h00, vec,   1'b1, 1'b0, 3'd0, 3'd0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        rst_n = 1'b0; ir_in = 8'h00; ltim = 1'b0; auto_eoi = 1'b0; inta_pulse = 1'b0;
        eoi_valid = 1'b0; eoi_cmd = 3'd0; eoi_level = 3'd0; interrupt_vector = 8'h00;
        #3;
        checkOutput("rst_irr",  irr, 8'h00);
        checkOutput("rst_isr",  isr, 8'h00);
        checkOutput("rst_prio", 8'(priority_rotate), 8'h00);
        checkOutput("rst_int",  8'(int_out), 8'h00);
        checkOutput("rst_vv",   8'(vector_valid), 8'h00);
        checkOutput("rst_vi",   8'(vector_index), 8'h00);
        #9 rst_n = 1'b1;
        tick();

        // Edge-mode acknowledge of IR2
        applyStimulus(8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("edge_irr_set", irr, 8'h04);
        applyStimulus(8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("edge_int_hi", 8'(int_out), 8'h01);
        applyStimulus(8'h04, 8'h04, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("ack1_isr", isr, 8'h04);
        checkOutput("ack1_irr", irr, 8'h00);
        checkOutput("ack1_int", 8'(int_out), 8'h00);
        applyStimulus(8'h04, 8'h04, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("ack1_hold_int", 8'(int_out), 8'h00);
        checkOutput("ack1_hold_vv",  8'(vector_valid), 8'h00);
        applyStimulus(8'h04, 8'h04, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("ack2_vv",  8'(vector_valid), 8'h01);
        checkOutput("ack2_vi",  8'(vector_index), 8'h02);
        checkOutput("ack2_int", 8'(int_out), 8'h00);
        checkOutput("ack2_isr", isr, 8'h04);
        applyStimulus(8'h04, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("post_vv",  8'(vector_valid), 8'h00);
        checkOutput("post_isr", isr, 8'h04);
        checkOutput("post_irr", irr, 8'h00);
        applyEoi(3'b011, 3'd2);
        checkOutput("spec_eoi_isr", isr, 8'h00);

        // Level mode: held request re-enters IRR after acknowledge
        ltim = 1'b1;
        applyStimulus(8'h08, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("lvl_irr_set", irr, 8'h08);
        applyStimulus(8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("lvl_isr", isr, 8'h08);
        applyStimulus(8'h08, 8'h08, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("lvl_irr_reset", irr, 8'h08);
        applyStimulus(8'h08, 8'h08, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("lvl_vi", 8'(vector_index), 8'h03);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("lvl_irr_drop", irr, 8'h00);
        applyEoi(3'b001, 3'd0);
        checkOutput("nonspec_isr", isr, 8'h00);
        ltim = 1'b0;

        // Rotating EOI variants
        runInta(8'h04);
        runInta(8'h20);
        checkOutput("isr_24", isr, 8'h24);
        applyEoi(3'b101, 3'd0);
        checkOutput("rot_ns_isr",  isr, 8'h20);
        checkOutput("rot_ns_prio", 8'(priority_rotate), 8'h03);
        runInta(8'h01);
        runInta(8'h08);
        checkOutput("isr_29", isr, 8'h29);
        applyEoi(3'b001, 3'd0);
        checkOutput("ns_from3", isr, 8'h21);
        applyEoi(3'b001, 3'd0);
        checkOutput("ns_lvl5", isr, 8'h01);
        applyEoi(3'b101, 3'd0);
        checkOutput("rot_wrap_isr",  isr, 8'h00);
        checkOutput("rot_wrap_prio", 8'(priority_rotate), 8'h01);
        applyEoi(3'b101, 3'd0);
        checkOutput("rot_empty_prio", 8'(priority_rotate), 8'h01);
        applyEoi(3'b110, 3'd7);
        checkOutput("setprio_wrap", 8'(priority_rotate), 8'h00);
        applyEoi(3'b111, 3'd4);
        checkOutput("rot_spec_prio", 8'(priority_rotate), 8'h05);
        runInta(8'h40);
        applyEoi(3'b000, 3'd6);
        checkOutput("nop000_isr", isr, 8'h40);
        applyEoi(3'b010, 3'd6);
        checkOutput("nop010_isr",  isr, 8'h40);
        checkOutput("nop010_prio", 8'(priority_rotate), 8'h05);
        applyEoi(3'b100, 3'd6);
        checkOutput("nop100_isr", isr, 8'h40);
        applyEoi(3'b011, 3'd6);
        checkOutput("spec6_isr", isr, 8'h00);

        // Auto-EOI on level 5, with INTA held into ACK2
        auto_eoi = 1'b1;
        applyStimulus(8'h00, 8'h20, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("aeoi_ack1_isr", isr, 8'h20);
        applyStimulus(8'h00, 8'h20, 1'b0, 1'b0, 3'd0, 3'd0);
        applyStimulus(8'h00, 8'h20, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("aeoi_ack2_isr", isr, 8'h00);
        checkOutput("aeoi_vi", 8'(vector_index), 8'h05);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("ack2_inta_vv", 8'(vector_valid), 8'h00);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("ack2_inta_vv2", 8'(vector_valid), 8'h00);
        auto_eoi = 1'b0;

        // Spurious acknowledge
        runInta(8'h02);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("spur_ack1_isr", isr, 8'h02);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("spur_vv",  8'(vector_valid), 8'h01);
        checkOutput("spur_vi",  8'(vector_index), 8'h07);
        checkOutput("spur_isr", isr, 8'h02);
        applyEoi(3'b011, 3'd1);
        checkOutput("spur_clean_isr", isr, 8'h00);

        // Reset in the middle of an acknowledge
        applyEoi(3'b110, 3'd2);
        checkOutput("pre_rst_prio", 8'(priority_rotate), 8'h03);
        ltim = 1'b1;
        applyStimulus(8'h10, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        applyStimulus(8'h10, 8'h10, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("pre_rst_isr", isr, 8'h10);
        inta_pulse = 1'b0;
        ltim = 1'b0;
        ir_in = 8'h01;
        interrupt_vector = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_irr",  irr, 8'h00);
        checkOutput("mid_rst_isr",  isr, 8'h00);
        checkOutput("mid_rst_prio", 8'(priority_rotate), 8'h00);
        checkOutput("mid_rst_int",  8'(int_out), 8'h00);
        checkOutput("mid_rst_vv",   8'(vector_valid), 8'h00);
        checkOutput("mid_rst_vi",   8'(vector_index), 8'h00);
        tick();
        #2 rst_n = 1'b1;
        applyStimulus(8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("post_rst_irr", irr, 8'h00);
        checkOutput("post_rst_vv",  8'(vector_valid), 8'h00);
        applyStimulus(8'h01, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);
        checkOutput("post_rst_vv2", 8'(vector_valid), 8'h00);
        applyStimulus(8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 3'd0);
        checkOutput("post_rst_seq_vv", 8'(vector_valid), 8'h01);
        checkOutput("post_rst_seq_vi", 8'(vector_index), 8'h07);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 ir_in  input  8  raw interrupt request lines IR0..IR7, already synchronised to clk.
REQ-004 ltim  input  1  trigger mode: 1 = level-triggered, 0 = edge-triggered.
REQ-005 auto_eoi  input  1  1 = ISR bit cleared automatically at second INTA.
REQ-006 inta_pulse  input  1  one-cycle strobe per INTA cycle from the bus interface.
REQ-007 eoi_valid  input  1  one-cycle strobe qualifying eoi_cmd/eoi_level (OCW2 write).
REQ-008 eoi_cmd  input  3  OCW2 {R,SL,EOI} bits.
REQ-009 eoi_level  input  3  OCW2 L2..L0.
REQ-010 interrupt_vector  input  8  one-hot (or zero) winning request from the priority resolver.
REQ-011 irr  output  8  interrupt request register, drives the resolver.
REQ-012 isr  output  8  in-service register, drives the resolver.
REQ-013 priority_rotate  output  3  level currently holding highest priority, drives the resolver.
REQ-014 int_out  output  1  interrupt request to the CPU.
REQ-015 vector_index  output  3  encoded level acknowledged, valid while vector_valid=1.
REQ-016 vector_valid  output  1  one-cycle strobe in the cycle after the second INTA.

Function
REQ-017 Edge mode: irr[i] sets on ir_in[i] 0->1 (vs. registered ir_prev[i]); clears when ir_in[i]=0 or on acknowledge.
REQ-018 Level mode: irr[i] sets while ir_in[i]=1; clears when ir_in[i]=0 or on acknowledge.
REQ-019 Same-cycle set condition and acknowledge-clear on one irr bit: set wins.
REQ-020 FSM states IDLE, ACK1, ACK2; IDLE->ACK1 on inta_pulse; ACK1->ACK2 on inta_pulse; ACK2->IDLE next cycle.
REQ-021 IDLE->ACK1 transition: latch interrupt_vector into ack_latch; set matching isr bit; clear matching irr bit.
REQ-022 Spurious case (interrupt_vector=0 at first INTA): no isr/irr change; ack_latch records level 7.
REQ-023 ACK2 entry: vector_index = encoded ack_latch, vector_valid=1 for exactly one cycle; if auto_eoi=1 and not spurious, clear that isr bit in the same cycle.
REQ-024 int_out = (interrupt_vector != 0) in IDLE only; 0 in ACK1 and ACK2; registered, one cycle latency.
REQ-025 eoi_cmd 001 non-specific EOI: clear highest-priority set isr bit (search starts at priority_rotate, wraps 7->0); no-op if isr=0.
REQ-026 eoi_cmd 011 specific EOI: clear isr[eoi_level].
REQ-027 eoi_cmd 101 rotate on non-specific: as 001, and priority_rotate = (cleared level + 1) mod 8; no change if isr=0.
REQ-028 eoi_cmd 111 rotate on specific: clear isr[eoi_level]; priority_rotate = (eoi_level + 1) mod 8.
REQ-029 eoi_cmd 110 set priority: priority_rotate = (eoi_level + 1) mod 8; isr unchanged.
REQ-030 eoi_cmd 000, 010, 100: no-op.
REQ-031 EOI and acknowledge in same cycle: EOI evaluates pre-cycle isr; clear applied before set (set wins on same bit).
REQ-032 inta_pulse while ACK2: ignored.

Reset
REQ-033 rst_n=0 forces immediately: irr=0, isr=0, priority_rotate=0, state=IDLE, ack_latch=0, int_out=0, vector_index=0, vector_valid=0, ir_prev=8'hFF (lines high at reset never count as edges).
REQ-034 Reset asserted mid-INTA sequence abandons the sequence; no vector_valid issued.

Structure
REQ-035 Shared package pic_pkg holds FSM state enum, OCW2 eoi_cmd encodings, and the rotating highest-priority-search function.
REQ-036 One sub-module pic_irr_latch (ir_prev, edge/level logic, irr register); FSM and ISR logic in top level.

Verification
REQ-037 Edge mode, ir_in 00->04, interrupt_vector=04, two inta_pulse -> isr=04, irr=00, vector_index=2, vector_valid one cycle, int_out low during ACK1/ACK2.
REQ-038 Level mode, ir_in held 08 through ack -> irr[3] re-sets the cycle after acknowledge clear.
REQ-039 isr=0x24, priority_rotate=0, eoi_cmd 101 -> isr=0x20, priority_rotate=3.
REQ-040 auto_eoi=1, acknowledge level 5 -> isr[5] set in ACK1, cleared on ACK2 entry.
REQ-041 Spurious: interrupt_vector=0 at first INTA -> isr unchanged, vector_index=7.
REQ-042 rst_n low in ACK1 -> all outputs reset values, state IDLE, no vector_valid.
